// File: rtl/pad_write_scheduler_pkg.sv
// Shared accelerator definitions: default lane count, address width and the
// write-scheduler state encoding.
package pad_write_scheduler_pkg;
  localparam int PE_DEFAULT = 16;
  localparam int AW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pws_state_e;
endpackage

// File: rtl/pad_write_scheduler_border.sv
// Zero-border walker: steps through the padded frame border in raster order,
// WPP words per visited pixel, and reports the buffer address of the current word.
module pad_border_walker #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init,
  input  logic          step,
  input  logic [8:0]    pw,
  input  logic [7:0]    wpp,
  output logic [AW-1:0] pad_addr,
  output logic          last
);
  localparam int IW = AW + 17;

  logic [8:0]    row_r, col_r, row_s, col_s;
  logic [7:0]    k_r, k_s;
  logic          k_last_s, col_last_s, edge_row_s;
  logic [IW-1:0] addr_s;
  logic          unused_addr_hi_s;

  assign k_last_s   = (k_r == (wpp - 8'd1));
  assign col_last_s = (col_r == (pw - 9'd1));
  assign edge_row_s = (row_r == 9'd0) || (row_r == (pw - 9'd1));
  assign last       = (row_r == (pw - 9'd1)) && col_last_s && k_last_s;

  assign addr_s   = (IW'(row_r) * IW'(pw) + IW'(col_r)) * IW'(wpp) + IW'(k_r);
  assign pad_addr = addr_s[AW-1:0];
  assign unused_addr_hi_s = ^addr_s[IW-1:AW];

  // Next position: full rows at top and bottom, only the two side columns elsewhere.
  always_comb begin
    row_s = row_r;
    col_s = col_r;
    k_s   = k_r;
    if (init) begin
      row_s = 9'd0;
      col_s = 9'd0;
      k_s   = 8'd0;
    end else if (step) begin
      if (!k_last_s) begin
        k_s = k_r + 8'd1;
      end else begin
        k_s = 8'd0;
        if (edge_row_s) begin
          if (col_last_s) begin
            col_s = 9'd0;
            row_s = row_r + 9'd1;
          end else begin
            col_s = col_r + 9'd1;
          end
        end else begin
          if (col_r == 9'd0) begin
            col_s = pw - 9'd1;
          end else begin
            col_s = 9'd0;
            row_s = row_r + 9'd1;
          end
        end
      end
    end else begin
      row_s = row_r;
      col_s = col_r;
      k_s   = k_r;
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_r <= 9'd0;
      col_r <= 9'd0;
      k_r   <= 8'd0;
    end else begin
      row_r <= row_s;
      col_r <= col_s;
      k_r   <= k_s;
    end
  end
endmodule

// File: rtl/pad_write_scheduler.sv
// Feature-map write scheduler: places PE result words into a (optionally zero-padded)
// buffer, interleaving border zero writes into cycles where no data is accepted.
module pad_write_scheduler
  import pad_write_scheduler_pkg::*;
#(
  parameter int PE = PE_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [7:0]      cfg_c,
  input  logic [7:0]      cfg_w,
  input  logic            cfg_pad,
  input  logic            in_valid,
  input  logic [PE*8-1:0] in_data,
  output logic            in_ready,
  output logic            wr_en,
  output logic [AW-1:0]   wr_addr,
  output logic [PE*8-1:0] wr_data,
  output logic            busy,
  output logic            done
);
  localparam int IW = AW + 17;

  pws_state_e    state_r, state_s;
  logic [7:0]    wpp_r, w_r, d_row_r, d_col_r, d_k_r;
  logic [8:0]    pw_r;
  logic          pad_r, data_done_r, border_done_r;
  logic          accept_s, run_s, data_take_s, border_take_s, data_last_s, frame_end_s;
  logic          data_done_s, b_last_s;
  logic [AW-1:0] b_addr_s;
  logic [IW-1:0] d_addr_s;
  logic          unused_d_addr_hi_s;
  logic          wr_en_r, busy_r, done_r, in_ready_r;
  logic [AW-1:0] wr_addr_r;
  logic [PE*8-1:0] wr_data_r;

  assign accept_s      = (state_r == ST_IDLE) && start;
  assign run_s         = (state_r == ST_RUN);
  assign data_take_s   = in_ready_r && in_valid;
  assign border_take_s = run_s && !data_take_s && !border_done_r;
  assign data_last_s   = (d_row_r == (w_r - 8'd1)) && (d_col_r == (w_r - 8'd1)) &&
                         (d_k_r == (wpp_r - 8'd1));
  assign frame_end_s   = (data_take_s && data_last_s && border_done_r) ||
                         (border_take_s && b_last_s && data_done_r);
  assign data_done_s   = accept_s ? 1'b0 : (data_done_r || (data_take_s && data_last_s));

  // Data pixel (r, c) lands at padded pixel (r+pad, c+pad).
  assign d_addr_s = ((IW'(d_row_r) + IW'(pad_r)) * IW'(pw_r) + IW'(d_col_r) + IW'(pad_r))
                    * IW'(wpp_r) + IW'(d_k_r);
  assign unused_d_addr_hi_s = ^d_addr_s[IW-1:AW];

  pad_border_walker #(.AW(AW)) u_border (
    .clk      (clk),
    .rst_n    (rst_n),
    .init     (accept_s),
    .step     (border_take_s),
    .pw       (pw_r),
    .wpp      (wpp_r),
    .pad_addr (b_addr_s),
    .last     (b_last_s)
  );

  // Frame FSM next-state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: if (start) state_s = ST_RUN; else state_s = ST_IDLE;
      ST_RUN:  if (frame_end_s) state_s = ST_DONE; else state_s = ST_RUN;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, latched configuration and data/border progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      wpp_r         <= 8'd0;
      w_r           <= 8'd0;
      pw_r          <= 9'd0;
      pad_r         <= 1'b0;
      d_row_r       <= 8'd0;
      d_col_r       <= 8'd0;
      d_k_r         <= 8'd0;
      data_done_r   <= 1'b0;
      border_done_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_done_r <= data_done_s;
      if (accept_s) begin
        wpp_r         <= 8'(int'(cfg_c) / PE);
        w_r           <= cfg_w;
        pw_r          <= {1'b0, cfg_w} + (cfg_pad ? 9'd2 : 9'd0);
        pad_r         <= cfg_pad;
        d_row_r       <= 8'd0;
        d_col_r       <= 8'd0;
        d_k_r         <= 8'd0;
        border_done_r <= !cfg_pad;
      end else begin
        if (data_take_s) begin
          if (d_k_r == (wpp_r - 8'd1)) begin
            d_k_r <= 8'd0;
            if (d_col_r == (w_r - 8'd1)) begin
              d_col_r <= 8'd0;
              d_row_r <= d_row_r + 8'd1;
            end
            else d_col_r <= d_col_r + 8'd1;
          end
          else d_k_r <= d_k_r + 8'd1;
        end
        if (border_take_s && b_last_s) border_done_r <= 1'b1;
      end
    end
  end

  // Registered write port and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= {AW{1'b0}};
      wr_data_r  <= {(PE*8){1'b0}};
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      in_ready_r <= 1'b0;
    end else begin
      wr_en_r    <= data_take_s || border_take_s;
      wr_addr_r  <= data_take_s ? d_addr_s[AW-1:0] : b_addr_s;
      wr_data_r  <= data_take_s ? in_data : {(PE*8){1'b0}};
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= frame_end_s;
      in_ready_r <= (state_s == ST_RUN) && !data_done_s;
    end
  end

  assign in_ready = in_ready_r;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  assign wr_data  = wr_data_r;
  assign busy     = busy_r;
  assign done     = done_r;
endmodule

// File: tb/tb_pad_write_scheduler.sv
// Self-checking bench: queue-based reference of data and border writes per frame.
module tb_pad_write_scheduler;
  localparam int PE = 16;
  localparam int AW = 16;
  localparam int DW = PE * 8;

  logic          clk = 1'b0;
  logic          rst_n, start, cfg_pad, in_valid;
  logic [7:0]    cfg_c, cfg_w;
  logic [DW-1:0] in_data, wr_data;
  logic          in_ready, wr_en, busy, done;
  logic [AW-1:0] wr_addr;

  int checks = 0;
  int failures = 0;

  logic [AW-1:0] dq_addr[$];
  logic [DW-1:0] dq_data[$];
  logic [AW-1:0] bq_addr[$];

  pad_write_scheduler #(.PE(PE), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_c(cfg_c), .cfg_w(cfg_w),
    .cfg_pad(cfg_pad), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr_en"}, DW'(wr_en), DW'(0));
    chk({tag, "_wr_addr"}, DW'(wr_addr), DW'(0));
    chk({tag, "_wr_data"}, wr_data, DW'(0));
    chk({tag, "_busy"}, DW'(busy), DW'(0));
    chk({tag, "_done"}, DW'(done), DW'(0));
    chk({tag, "_in_ready"}, DW'(in_ready), DW'(0));
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // mode: 0 valid low until border drained then after a stall, 1 continuous,
  // 2 toggling, 3 random. abort_after >= 0 resets after that many writes.
  task automatic run_frame(input int c, input int w, input int pad, input int mode,
                           input int abort_after, input bit spur);
    int wpp, pw, writes, cyc, stall, phase;
    bit v, e_en;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
    wpp = c / PE;
    pw  = w + 2 * pad;
    dq_addr.delete(); dq_data.delete(); bq_addr.delete();
    for (int r = 0; r < w; r++)
      for (int cc = 0; cc < w; cc++)
        for (int k = 0; k < wpp; k++) begin
          dq_addr.push_back(AW'(((r + pad) * pw + cc + pad) * wpp + k));
          dq_data.push_back(rand_word());
        end
    if (pad != 0)
      for (int r = 0; r < pw; r++)
        for (int cc = 0; cc < pw; cc++)
          if (r == 0 || r == pw - 1 || cc == 0 || cc == pw - 1)
            for (int k = 0; k < wpp; k++) bq_addr.push_back(AW'((r * pw + cc) * wpp + k));

    @(negedge clk);
    cfg_c = 8'(c); cfg_w = 8'(w); cfg_pad = (pad != 0); start = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    e_en = 1'b0; e_addr = '0; e_data = '0;
    phase = 0; writes = 0; cyc = 0; stall = 0;
    while (1) begin
      chk("busy", DW'(busy), DW'(1));
      chk("in_ready", DW'(in_ready), DW'(phase == 0 && dq_addr.size() > 0));
      chk("wr_en", DW'(wr_en), DW'(e_en));
      chk("done", DW'(done), DW'(phase == 1));
      if (e_en) begin
        chk("wr_addr", DW'(wr_addr), DW'(e_addr));
        chk("wr_data", wr_data, e_data);
        writes++;
      end
      if (phase == 1) break;
      if (abort_after >= 0 && writes == abort_after) begin
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      cyc++;
      if (cyc > 5000) begin
        checks++; failures++;
        $display("FAIL timeout observed=%0d writes expected=%0d", writes, pw * pw * wpp);
        break;
      end
      start = spur && (cyc == 3);
      if (start) begin cfg_c = 8'd32; cfg_w = 8'd3; cfg_pad = 1'b0; end
      case (mode)
        0: begin
          if (bq_addr.size() > 0) v = 1'b0;
          else begin v = (stall >= 3); stall++; end
        end
        1: v = 1'b1;
        2: v = (cyc % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_data  = (v && dq_addr.size() > 0) ? dq_data[0] : rand_word();
      if (v && dq_addr.size() > 0) begin
        e_en = 1'b1; e_addr = dq_addr.pop_front(); e_data = dq_data.pop_front();
      end else if (bq_addr.size() > 0) begin
        e_en = 1'b1; e_addr = bq_addr.pop_front(); e_data = '0;
      end else begin
        e_en = 1'b0;
      end
      if (e_en && dq_addr.size() == 0 && bq_addr.size() == 0) phase = 1;
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    chk("write_count", DW'(writes), DW'(pw * pw * wpp));
    @(negedge clk);
    chk("post_busy", DW'(busy), DW'(0));
    chk("post_in_ready", DW'(in_ready), DW'(0));
    chk("post_wr_en", DW'(wr_en), DW'(0));
    chk("post_done", DW'(done), DW'(0));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_c = 8'd0; cfg_w = 8'd0; cfg_pad = 1'b0;
    in_valid = 1'b0; in_data = '0;
    #2;
    chk_idle_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("idle");

    run_frame(16, 2, 1, 0, -1, 1'b0);   // border first, data after stall
    run_frame(16, 2, 1, 1, -1, 1'b0);   // data first, border after
    run_frame(32, 2, 0, 1, -1, 1'b0);   // no padding, two words per pixel
    run_frame(16, 2, 1, 2, -1, 1'b0);   // toggling valid
    run_frame(16, 1, 0, 2, -1, 1'b0);   // single-word frame
    run_frame(16, 2, 1, 0, 6, 1'b0);    // reset mid-frame
    run_frame(16, 2, 1, 0, -1, 1'b1);   // fresh frame, stray start in RUN
    for (int i = 0; i < 5; i++)
      run_frame(PE * $urandom_range(1, 3), $urandom_range(1, 5), $urandom_range(0, 1), 3, -1,
                1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
